row_pattern_driver: RTL
=======================

Name: row_pattern_driver

Overview:
- Row-side counterpart of the 3-bit column ring counter in the LED matrix path.
- Samples the one-hot column select each clock and drives the row lines with that column's pattern from a double-buffered frame.
- Blanks the rows on every column change to prevent ghosting.
- Accepts new frames through a valid/ready handshake and swaps them in only at a scan boundary, so no frame ever tears.

Parameters:
- ROWS, 7: number of matrix rows (row pattern width).
- BLANK_CYCLES, 2: cycles rows are forced low after each column change; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- col  input  3  one-hot column select from the ring counter. Scan order 100 -> 010 -> 001 -> 100.
  - col[2] = outer columns 0/4.
  - col[1] = inner columns 1/3.
  - col[0] = centre column 2.
- frame_data  input  3*ROWS  new frame, three patterns:
  - [ROWS-1:0] = outer.
  - [2*ROWS-1:ROWS] = inner.
  - [3*ROWS-1:2*ROWS] = centre.
- frame_valid  input  1  frame_data is valid.
- frame_ready  output  1  driver can accept a frame.
- row  output  ROWS  row drive, active-high, registered.
- row_valid  output  1  row currently carries a pattern (not blank, not idle).
- col_error  output  1  last sampled col was not one-hot.

Behaviour:
- Reset (async, reset=0):
  - row=0, row_valid=0, col_error=0, frame_ready=1.
  - shadow and active buffers cleared, pending=0, col_q=100, state=IDLE, blank counter=0.
- All outputs are registered. col is sampled every rising edge; col_q holds the previous sample.
- Frame load:
  - Transfer when frame_valid && frame_ready: frame_data captured into shadow, pending<=1.
  - frame_ready = !pending, driven from the register.
  - Only one frame may be pending; frame_valid with frame_ready=0 is ignored and the source holds its data.
- Swap: when pending=1 and a sampled col of 100 differs from col_q (scan-cycle start), then:
  - active<=shadow, pending<=0 in that same edge.
  - frame_ready returns to 1 on the next cycle.
- A transfer and a swap in the same edge are impossible, since ready=0 while pending.
- State machine:
  - IDLE:
    - No frame loaded yet; row=0, row_valid=0.
    - First swap moves to BLANK.
    - Before the first swap, col changes are tracked in col_q but rows stay dark.
  - BLANK:
    - row=0, row_valid=0; counter loads BLANK_CYCLES on entry and decrements each cycle.
    - At counter==1, next state is DRIVE.
  - DRIVE:
    - row = active pattern selected by col_q; row_valid=1.
    - Holds until col changes, then goes to BLANK.
- Latency, col change sampled at edge N:
  - row=0 from after edge N through BLANK_CYCLES cycles.
  - New pattern appears after edge N+BLANK_CYCLES.
- A col change during BLANK reloads the counter (restart blanking); the pattern follows the newest col.
- Invalid col (000 or more than one bit set), from any non-IDLE state:
  - col_error<=1, go to BLANK, row=0.
  - Counter is held at BLANK_CYCLES while col stays invalid.
  - Once a valid one-hot is sampled, col_error<=0 and normal blanking counts down from that sample.
  - Invalid col never triggers a swap.
- In IDLE, invalid col sets col_error but the state stays IDLE.
- Reset mid-frame: pending shadow is discarded, and the display goes dark until a new frame is loaded and swapped.

Decomposition:
- Shared package matrix_pkg holds:
  - state enum {IDLE, BLANK, DRIVE}.
  - column one-hot constants COL_OUTER=3'b100, COL_INNER=3'b010, COL_CENTRE=3'b001.
  - default ROWS.
- One natural sub-module: frame_double_buffer, covering shadow/active registers, pending flag and ready logic, with swap as an input strobe.
- Blanking FSM and pattern mux stay in the top module.

Test Plan:
1. Reset, then frame_data={C=7'h08, I=7'h14, O=7'h22} with valid, col held 001.
   - Required: ready falls; no swap, row stays 0 in IDLE.
   - Then col->100: after 2 blank cycles row=7'h22, row_valid=1.
2. Scan 100/010/001, 6 cycles each:
   - Required: each change gives exactly 2 cycles of row=0, then 7'h22 / 7'h14 / 7'h08 respectively.
3. Load a second frame mid-scan while col=010:
   - Required: ready=0; display keeps the old frame through 001; swap on next 100; ready=1 one cycle later.
   - Attempt a third frame while pending: it is not captured.
4. col=011 for 3 cycles during DRIVE:
   - Required: col_error=1, row=0 throughout.
   - Then col=001: col_error clears, row=7'h08 after 2 cycles.
5. col toggles every cycle 100/010 for 4 cycles:
   - Required: rows stay 0 (blank restarts each change).
   - Then col held: pattern appears after BLANK_CYCLES.
6. Assert reset=0 asynchronously mid-DRIVE with a frame pending:
   - Required: row=0, row_valid=0, ready=1 immediately with no clock edge.
   - After release, the state is IDLE until a new frame is loaded and swapped.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix row/column path.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [2:0] COL_OUTER  = 3'b100;
    localparam logic [2:0] COL_INNER  = 3'b010;
    localparam logic [2:0] COL_CENTRE = 3'b001;

    localparam int DEFAULT_ROWS = 7;

    function automatic logic is_one_hot(input logic [2:0] c);
        return (c == COL_OUTER) || (c == COL_INNER) || (c == COL_CENTRE);
    endfunction

endpackage

// File: rtl/frame_double_buffer.sv
// Shadow/active frame store: one pending frame at most, promoted to active on the swap strobe.
module frame_double_buffer
    import matrix_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3*ROWS-1:0] frame_data,
    input  logic              frame_valid,
    input  logic              swap,
    output logic              frame_ready,
    output logic              pending,
    output logic [3*ROWS-1:0] active
);

    logic [3*ROWS-1:0] shadow_q, shadow_d;
    logic [3*ROWS-1:0] active_q, active_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;
    logic              xfer_s;

    // Next-state for the buffers; a swap and a transfer never coincide because ready is low while pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        xfer_s    = frame_valid && ready_q;
        if (swap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (xfer_s) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        ready_d = !pending_d;
    end

    // Buffer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
        end
    end

    assign frame_ready = ready_q;
    assign pending     = pending_q;
    assign active      = active_q;

endmodule

// File: rtl/row_pattern_driver.sv
// Row driver: blanks on every column change, then drives the active frame's pattern for the sampled column.
module row_pattern_driver
    import matrix_pkg::*;
#(
    parameter int ROWS         = DEFAULT_ROWS,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        col,
    input  logic [3*ROWS-1:0] frame_data,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [ROWS-1:0]   row,
    output logic              row_valid,
    output logic              col_error
);

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        col_q;
    logic [ROWS-1:0]   row_q, row_d;
    logic              row_valid_q, row_valid_d;
    logic              col_error_q, col_error_d;
    logic              col_ok_s, col_chg_s, swap_s, pending_s;
    logic [3*ROWS-1:0] active_s;

    frame_double_buffer #(.ROWS(ROWS)) u_buf (
        .clock       (clock),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .swap        (swap_s),
        .frame_ready (frame_ready),
        .pending     (pending_s),
        .active      (active_s)
    );

    function automatic logic [ROWS-1:0] pick(input logic [3*ROWS-1:0] f, input logic [2:0] c);
        case (c)
            COL_OUTER:  return f[ROWS-1:0];
            COL_INNER:  return f[2*ROWS-1:ROWS];
            COL_CENTRE: return f[3*ROWS-1:2*ROWS];
            default:    return '0;
        endcase
    endfunction

    // Swap only at the start of a scan cycle: a fresh transition onto the outer column.
    always_comb begin
        col_ok_s  = is_one_hot(col);
        col_chg_s = (col != col_q);
        swap_s    = pending_s && (col == COL_OUTER) && col_chg_s;
    end

    // Blanking FSM and pattern selection, computed one cycle ahead of the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_error_d = !col_ok_s;
        case (state_q)
            IDLE: begin
                if (swap_s) begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            BLANK, DRIVE: begin
                // Recovery from an invalid column restarts blanking just like a column change.
                if (!col_ok_s || col_chg_s || col_error_q) begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                end else if (state_q == BLANK) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = DRIVE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (state_d == DRIVE) begin
            row_d       = pick(active_s, col);
            row_valid_d = 1'b1;
        end else begin
            row_d       = '0;
            row_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            col_q       <= COL_OUTER;
            row_q       <= '0;
            row_valid_q <= 1'b0;
            col_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            col_error_q <= col_error_d;
        end
    end

    assign row       = row_q;
    assign row_valid = row_valid_q;
    assign col_error = col_error_q;

endmodule
